// File: rtl/gamma_lut_arbiter_if.sv
// Request/response bundle for gamma_lut_arbiter.
// Valid/ready: a beat or result moves on any rising clk edge where valid && ready; valid never waits on ready.
interface gamma_lut_arbiter_if #(
  parameter int DW_IN  = 8,
  parameter int DW_OUT = 16
);
  logic [2:0]         req_valid;
  logic [3*DW_IN-1:0] req_data;
  logic [2:0]         req_ready;
  logic               rsp_valid;
  logic               rsp_ready;
  logic [1:0]         rsp_id;
  logic [DW_OUT-1:0]  rsp_data;

  modport master (
    output req_valid, req_data, rsp_ready,
    input  req_ready, rsp_valid, rsp_id, rsp_data
  );

  modport slave (
    input  req_valid, req_data, rsp_ready,
    output req_ready, rsp_valid, rsp_id, rsp_data
  );
endinterface

// File: rtl/gamma_lut_arbiter.sv
// Round-robin arbiter sharing one combinational gamma LUT between three requesters.
// Define GAMMA_LUT_ARB_OUT_REG_EN to add a second output register (latency 2, capacity 2).
module gamma_lut_arbiter #(
  parameter int DW_IN  = 8,
  parameter int DW_OUT = 16
) (
  input  logic              clk,
  input  logic              rst,
  gamma_lut_arbiter_if.slave bus,
  output logic [DW_IN-1:0]  lut_addr,
  input  logic [DW_OUT-1:0] lut_data,
  output logic [1:0]        dbg_ptr
);

  logic [1:0]        ptr, ptr_eff, grant_idx;
  logic              grant_found, fire, s1_free, s1_adv;
  logic              s1_valid;
  logic [1:0]        s1_id;
  logic [DW_OUT-1:0] s1_data;

  function automatic logic [1:0] rr_idx(input logic [1:0] base, input int k);
    int s;
    s = int'(base) + k;
    if (s >= 3) s = s - 3;
    return s[1:0];
  endfunction

  // An illegal pointer value of 3 behaves as 0.
  assign ptr_eff = (ptr == 2'd3) ? 2'd0 : ptr;
  assign dbg_ptr = ptr;

  always_comb begin
    grant_found = 1'b0;
    grant_idx   = ptr_eff;
    for (int k = 0; k < 3; k++) begin
      if (!grant_found && bus.req_valid[rr_idx(ptr_eff, k)]) begin
        grant_found = 1'b1;
        grant_idx   = rr_idx(ptr_eff, k);
      end
    end
  end

  always_comb begin
    case (grant_idx)
      2'd1:    lut_addr = bus.req_data[DW_IN +: DW_IN];
      2'd2:    lut_addr = bus.req_data[2*DW_IN +: DW_IN];
      default: lut_addr = bus.req_data[0 +: DW_IN];
    endcase
  end

`ifdef GAMMA_LUT_ARB_OUT_REG_EN
  logic              s2_valid, s2_free;
  logic [1:0]        s2_id;
  logic [DW_OUT-1:0] s2_data;

  assign s2_free       = !s2_valid || bus.rsp_ready;
  assign s1_adv        = s2_free;
  assign bus.rsp_valid = s2_valid;
  assign bus.rsp_id    = s2_id;
  assign bus.rsp_data  = s2_data;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2_valid <= 1'b0;
      s2_id    <= 2'd0;
      s2_data  <= '0;
    end else if (s1_valid && s2_free) begin
      s2_valid <= 1'b1;
      s2_id    <= s1_id;
      s2_data  <= s1_data;
    end else if (bus.rsp_ready) begin
      s2_valid <= 1'b0;
    end
  end
`else
  assign s1_adv        = bus.rsp_ready;
  assign bus.rsp_valid = s1_valid;
  assign bus.rsp_id    = s1_id;
  assign bus.rsp_data  = s1_data;
`endif

  // Accept only when the capture stage is empty or drains this same edge.
  assign s1_free       = !s1_valid || s1_adv;
  assign fire          = grant_found && s1_free && !rst;
  assign bus.req_ready = fire ? (3'b001 << grant_idx) : 3'b000;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr      <= 2'd0;
      s1_valid <= 1'b0;
      s1_id    <= 2'd0;
      s1_data  <= '0;
    end else if (fire) begin
      ptr      <= (grant_idx == 2'd2) ? 2'd0 : grant_idx + 2'd1;
      s1_valid <= 1'b1;
      s1_id    <= grant_idx;
      s1_data  <= lut_data;
    end else begin
      ptr <= ptr_eff;
      if (s1_adv) s1_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_gamma_lut_arbiter.sv
// Randomized and directed bench for gamma_lut_arbiter against a queue-based reference model.
// Honours GAMMA_LUT_ARB_OUT_REG_EN to select latency/capacity of the model.
module tb_gamma_lut_arbiter;
  localparam int DW_IN  = 8;
  localparam int DW_OUT = 16;
`ifdef GAMMA_LUT_ARB_OUT_REG_EN
  localparam int LAT = 2;
  localparam int CAP = 2;
`else
  localparam int LAT = 1;
  localparam int CAP = 1;
`endif

  logic              clk = 1'b0;
  logic              rst;
  logic [DW_IN-1:0]  lut_addr;
  logic [DW_OUT-1:0] lut_data;
  logic [1:0]        dbg_ptr;

  gamma_lut_arbiter_if #(.DW_IN(DW_IN), .DW_OUT(DW_OUT)) bus ();

  gamma_lut_arbiter #(.DW_IN(DW_IN), .DW_OUT(DW_OUT)) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus.slave),
    .lut_addr (lut_addr),
    .lut_data (lut_data),
    .dbg_ptr  (dbg_ptr)
  );

  always #5 clk = ~clk;

  // Gamma-2 power curve in 1.15: 0 -> 0, 255 -> 32767.
  function automatic logic [DW_OUT-1:0] lut_fn(input logic [DW_IN-1:0] a);
    longint v;
    v = (longint'(a) * longint'(a) * 32767) / (255 * 255);
    return v[DW_OUT-1:0];
  endfunction

  assign lut_data = lut_fn(lut_addr);

  // Scoreboard: {id, data} in acceptance order, with cycles since acceptance.
  logic [DW_OUT+1:0] exp_q[$];
  int                age_q[$];
  int                m_ptr;
  int                checks = 0;
  int                errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [DW_IN-1:0] slice(input int i);
    return bus.req_data[i*DW_IN +: DW_IN];
  endfunction

  task automatic model_clear();
    exp_q.delete();
    age_q.delete();
    m_ptr = 0;
  endtask

  task automatic drive(input logic [2:0] v, input logic [3*DW_IN-1:0] d, input logic r);
    bus.req_valid = v;
    bus.req_data  = d;
    bus.rsp_ready = r;
  endtask

  // Check outputs mid-cycle against the model, advance the model, then step past the edge.
  task automatic tick();
    int        g;
    bit        head_vis, acc_ok;
    logic [2:0] exp_rdy;
    @(negedge clk);
    if (rst) begin
      check_eq("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
      check_eq("rst_req_ready", 32'(bus.req_ready), 32'd0);
      check_eq("rst_rsp_id",    32'(bus.rsp_id),    32'd0);
      check_eq("rst_rsp_data",  32'(bus.rsp_data),  32'd0);
      check_eq("rst_ptr",       32'(dbg_ptr),       32'd0);
    end else begin
      head_vis = (exp_q.size() > 0) && (age_q[0] >= LAT);
      check_eq("rsp_valid", 32'(bus.rsp_valid), 32'(head_vis));
      if (head_vis) begin
        check_eq("rsp_id",   32'(bus.rsp_id),   32'(exp_q[0][DW_OUT +: 2]));
        check_eq("rsp_data", 32'(bus.rsp_data), 32'(exp_q[0][DW_OUT-1:0]));
      end
      g = -1;
      for (int k = 0; k < 3; k++)
        if (g < 0 && bus.req_valid[(m_ptr + k) % 3]) g = (m_ptr + k) % 3;
      acc_ok  = (exp_q.size() < CAP) || (bus.rsp_ready && head_vis);
      exp_rdy = (g >= 0 && acc_ok) ? (3'b001 << g) : 3'b000;
      check_eq("req_ready", 32'(bus.req_ready), 32'(exp_rdy));
      check_eq("lut_addr",  32'(lut_addr), 32'(slice(g >= 0 ? g : m_ptr)));
      check_eq("ptr",       32'(dbg_ptr),  32'(m_ptr));
      if (head_vis && bus.rsp_ready) begin
        void'(exp_q.pop_front());
        void'(age_q.pop_front());
      end
      if (exp_rdy != 3'b000) begin
        exp_q.push_back({2'(g), lut_fn(slice(g))});
        age_q.push_back(0);
        m_ptr = (g + 1) % 3;
      end
      foreach (age_q[i]) age_q[i]++;
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    drive(3'b000, '0, 1'b0);
    model_clear();
    tick();
    tick();
    rst = 1'b0;

    // Single beat from requester 1 with the full-scale pixel.
    drive(3'b010, {8'd0, 8'd255, 8'd0}, 1'b1);
    #1;
    check_eq("single_ready", 32'(bus.req_ready), 32'h2);
    tick();
    drive(3'b000, '0, 1'b1);
    for (int k = 1; k <= LAT; k++) begin
      if (k > 1) tick();
      check_eq("single_valid", 32'(bus.rsp_valid), 32'(k == LAT));
      if (k == LAT) begin
        check_eq("single_id",   32'(bus.rsp_id),   32'd1);
        check_eq("single_data", 32'(bus.rsp_data), 32'd32767);
        check_eq("single_ptr",  32'(dbg_ptr),      32'd2);
      end
    end
    repeat (3) tick();

    // Round-robin with all requesters valid.
    for (int i = 0; i < 8; i++) begin
      drive(3'b111, 24'($urandom), 1'b1);
      tick();
    end

    // Backpressure then release.
    for (int i = 0; i < 4; i++) begin
      drive(3'b111, 24'($urandom), 1'b0);
      tick();
    end
    for (int i = 0; i < 6; i++) begin
      drive(3'b111, 24'($urandom), 1'b1);
      tick();
    end

    // Reset while a result is on the output.
    check_eq("pre_rst_valid", 32'(bus.rsp_valid), 32'd1);
    rst = 1'b1;
    #1;
    check_eq("async_rst_valid", 32'(bus.rsp_valid), 32'd0);
    check_eq("async_rst_ready", 32'(bus.req_ready), 32'd0);
    model_clear();
    tick();
    rst = 1'b0;
    drive(3'b110, 24'($urandom), 1'b1);
    #1;
    check_eq("first_grant", 32'(bus.req_ready), 32'h2);
    tick();

    // Random traffic with random backpressure.
    for (int i = 0; i < 500; i++) begin
      drive(3'($urandom_range(0, 7)), 24'($urandom), ($urandom_range(0, 3) != 0));
      tick();
    end
    drive(3'b000, '0, 1'b1);
    repeat (4) tick();
    check_eq("drained", 32'(exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
